// File: rtl/flac_lpc_pkg.sv
// rtl/flac_lpc_pkg.sv - shared types and constants for the LPC recursion blocks
package flac_lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    localparam int          LPC_MAX_ORDER = 12;
    localparam int          LPC_TIMEOUT   = 63;
    localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
    localparam logic [31:0] FP_ONE        = 32'h3F80_0000;

    // Two coefficient pairs per beat, so an order-m dot product takes ceil(m/2) beats.
    function automatic logic [2:0] beats_for(input logic [3:0] m);
        logic [4:0] t;
        t = {1'b0, m} + 5'd1;
        return t[3:1];
    endfunction

endpackage

// File: rtl/alpha_sequencer_if.sv
// rtl/alpha_sequencer_if.sv - coefficient RAM and alpha accumulator bus
interface alpha_sequencer_if;

    logic [3:0]  oACFAddr1;
    logic [3:0]  oACFAddr2;
    logic [3:0]  oModelAddr1;
    logic [3:0]  oModelAddr2;
    logic [31:0] iACFData1;
    logic [31:0] iACFData2;
    logic [31:0] iModelData1;
    logic [31:0] iModelData2;
    logic        oCalcReset;
    logic        oCalcEnable;
    logic        oCalcValid;
    logic [3:0]  oCalcM;
    logic [31:0] oACF1;
    logic [31:0] oACF2;
    logic [31:0] oModel1;
    logic [31:0] oModel2;
    logic [31:0] iCalcAlpha;
    logic        iCalcDone;

    modport master (
        output oACFAddr1, oACFAddr2, oModelAddr1, oModelAddr2,
        input  iACFData1, iACFData2, iModelData1, iModelData2,
        output oCalcReset, oCalcEnable, oCalcValid, oCalcM,
        output oACF1, oACF2, oModel1, oModel2,
        input  iCalcAlpha, iCalcDone
    );

    modport slave (
        input  oACFAddr1, oACFAddr2, oModelAddr1, oModelAddr2,
        output iACFData1, iACFData2, iModelData1, iModelData2,
        input  oCalcReset, oCalcEnable, oCalcValid, oCalcM,
        input  oACF1, oACF2, oModel1, oModel2,
        output iCalcAlpha, iCalcDone
    );

endinterface

// File: rtl/alpha_sequencer.sv
// rtl/alpha_sequencer.sv - sequences one alpha_m dot product through the two-lane accumulator
module alpha_sequencer
    import flac_lpc_pkg::*;
#(
    parameter int MAX_ORDER = LPC_MAX_ORDER,
    parameter int TIMEOUT   = LPC_TIMEOUT
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [3:0]        iM,
    output logic              oBusy,
    output logic [31:0]       oAlpha,
    output logic              oAlphaValid,
    output logic              oError,
    alpha_sequencer_if.master calc
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      MAX_M   = 4'(MAX_ORDER);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    seq_state_t      state_q, state_d;
    logic [3:0]      m_q;
    logic [2:0]      n_q;
    logic [2:0]      beat_q;
    logic [WD_W-1:0] wd_q;
    logic            error_q;
    logic [31:0]     alpha_q;

    logic            m_legal;
    logic            raise_error;
    logic            take_alpha;
    logic            addr_phase;
    logic            feed_last;
    logic [3:0]      j;

    assign m_legal    = (iM != 4'd0) && (iM <= MAX_M);
    assign j          = {beat_q, 1'b0};
    assign addr_phase = ((state_q == ST_CLR) || (state_q == ST_FEED)) && (beat_q < n_q);
    // beat_q runs one ahead of the returning data, so it equals N on the final data beat.
    assign feed_last  = (beat_q == n_q);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            beat_q  <= '0;
            wd_q    <= '0;
            error_q <= 1'b0;
            alpha_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= raise_error;
            if ((state_q == ST_IDLE) && iStart && m_legal) begin
                m_q    <= iM;
                n_q    <= beats_for(iM);
                beat_q <= '0;
            end
            if (((state_q == ST_CLR) || (state_q == ST_FEED)) && (beat_q != '1)) begin
                beat_q <= beat_q + 3'd1;
            end
            if (state_q != ST_WAIT) begin
                wd_q <= '0;
            end else if (wd_q != '1) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (take_alpha) begin
                alpha_q <= calc.iCalcAlpha;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        raise_error = 1'b0;
        take_alpha  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (m_legal) state_d = ST_CLR;
                    else         raise_error = 1'b1;
                end
            end
            ST_CLR:  state_d = ST_FEED;
            ST_FEED: if (feed_last) state_d = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the last watchdog cycle still counts.
                if (calc.iCalcDone) begin
                    take_alpha = 1'b1;
                    state_d    = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    raise_error = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign oBusy       = (state_q != ST_IDLE);
    assign oAlpha      = alpha_q;
    assign oAlphaValid = (state_q == ST_DONE);
    assign oError      = error_q;

    assign calc.oCalcReset  = iReset || (state_q == ST_CLR);
    assign calc.oCalcEnable = oBusy;
    assign calc.oCalcValid  = (state_q == ST_FEED);
    assign calc.oCalcM      = oBusy ? m_q : 4'd0;

    assign calc.oModelAddr1 = addr_phase ? j : 4'd0;
    assign calc.oModelAddr2 = addr_phase ? j + 4'd1 : 4'd0;
    assign calc.oACFAddr2   = addr_phase ? m_q - j : 4'd0;
    assign calc.oACFAddr1   = addr_phase ? m_q - j - 4'd1 : 4'd0;

    assign calc.oModel1 = calc.oCalcValid ? calc.iModelData1 : FP_ZERO;
    assign calc.oACF1   = calc.oCalcValid ? calc.iACFData1 : FP_ZERO;
    assign calc.oACF2   = calc.oCalcValid ? calc.iACFData2 : FP_ZERO;
    // Odd m leaves a dangling second lane on the final beat.
    assign calc.oModel2 = (calc.oCalcValid && !(feed_last && m_q[0])) ? calc.iModelData2 : FP_ZERO;

endmodule

// File: tb/tb_alpha_sequencer.sv
// tb/tb_alpha_sequencer.sv - randomized self-checking bench for alpha_sequencer
module tb_alpha_sequencer;
    import flac_lpc_pkg::*;

    localparam int TIMEOUT = 63;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iStart = 1'b0;
    logic [3:0]  iM     = 4'd0;
    logic        oBusy;
    logic [31:0] oAlpha;
    logic        oAlphaValid;
    logic        oError;

    alpha_sequencer_if bus();

    alpha_sequencer #(.MAX_ORDER(12), .TIMEOUT(TIMEOUT)) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iM          (iM),
        .oBusy       (oBusy),
        .oAlpha      (oAlpha),
        .oAlphaValid (oAlphaValid),
        .oError      (oError),
        .calc        (bus.master)
    );

    always #5 iClock = ~iClock;

    logic [31:0] acf   [16];
    logic [31:0] model [16];
    int          n_checks   = 0;
    int          n_fail     = 0;
    logic [31:0] last_alpha = 32'd0;

    // Exact conversions for the small half-integer values this bench uses.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'd0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] rand_val();
        int v;
        v = int'($urandom_range(0, 32)) - 16;
        return r2f(real'(v) * 0.5);
    endfunction

    function automatic logic [31:0] ref_alpha(input int m);
        real s;
        s = 0.0;
        for (int k = 0; k < m; k++) s = s + f2r(model[k]) * f2r(acf[m - k]);
        return r2f(s);
    endfunction

    // Coefficient RAMs, one-cycle read latency.
    always @(posedge iClock) begin
        bus.iACFData1   <= acf[bus.oACFAddr1];
        bus.iACFData2   <= acf[bus.oACFAddr2];
        bus.iModelData1 <= model[bus.oModelAddr1];
        bus.iModelData2 <= model[bus.oModelAddr2];
    end

    // Accumulator: sums operand products, raises level done acc_lat cycles after the last beat.
    int          acc_lat   = 0;
    bit          acc_hold  = 1'b0;
    real         acc_sum   = 0.0;
    int          acc_beats = 0;
    int          acc_wait  = 0;
    logic        acc_done  = 1'b0;
    logic [31:0] acc_alpha = 32'd0;

    assign bus.iCalcDone  = acc_done;
    assign bus.iCalcAlpha = acc_alpha;

    function automatic real beat_prod();
        return f2r(bus.oModel1) * f2r(bus.oACF2) + f2r(bus.oModel2) * f2r(bus.oACF1);
    endfunction

    always @(posedge iClock) begin
        if (bus.oCalcReset) begin
            acc_done  <= 1'b0;
            acc_sum   <= 0.0;
            acc_beats <= 0;
            acc_wait  <= 0;
        end else if (bus.oCalcValid) begin
            acc_sum   <= acc_sum + beat_prod();
            acc_beats <= acc_beats + 1;
            if ((acc_beats + 1 == (int'(bus.oCalcM) + 1) / 2) && !acc_hold) begin
                if (acc_lat == 0) begin
                    acc_done  <= 1'b1;
                    acc_alpha <= r2f(acc_sum + beat_prod());
                end else begin
                    acc_wait <= acc_lat;
                end
            end
        end else if (acc_wait > 0) begin
            acc_wait <= acc_wait - 1;
            if (acc_wait == 1) begin
                acc_done  <= 1'b1;
                acc_alpha <= r2f(acc_sum);
            end
        end
    end

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_addr(input int m, input int k);
        int jj;
        jj = 2 * k;
        check_eq("addr_model1", 32'(bus.oModelAddr1), 32'(jj));
        check_eq("addr_model2", 32'(bus.oModelAddr2), 32'(jj + 1));
        check_eq("addr_acf2",   32'(bus.oACFAddr2),   32'(m - jj));
        check_eq("addr_acf1",   32'(bus.oACFAddr1),   32'(m - jj - 1));
    endtask

    task automatic check_ops(input int m, input int k, input int n);
        int jj;
        jj = 2 * k;
        check_eq("op_model1", bus.oModel1, model[jj]);
        check_eq("op_acf2",   bus.oACF2,   acf[m - jj]);
        check_eq("op_acf1",   bus.oACF1,   acf[m - jj - 1]);
        check_eq("op_model2", bus.oModel2, ((m % 2 == 1) && (k == n - 1)) ? FP_ZERO : model[jj + 1]);
    endtask

    task automatic run_txn(input int m, input int lat, input bit hold, input logic [31:0] exp_alpha);
        int          n, c_av, c_err, n_av, n_err;
        logic [31:0] alpha_at_av;
        acc_lat  = lat;
        acc_hold = hold;
        iStart   = 1'b1;
        iM       = 4'(m);
        step();
        iStart = 1'b0;
        if (m < 1 || m > 12) begin
            check_eq("bad_m_err", 32'(oError), 32'd1);
            check_eq("bad_m_busy", 32'({oBusy, bus.oCalcReset}), 32'd0);
            step();
            check_eq("bad_m_err_pulse", 32'(oError), 32'd0);
            check_eq("bad_m_busy2", 32'({oBusy, bus.oCalcReset}), 32'd0);
            return;
        end
        n = (m + 1) / 2;
        check_eq("clr_ctrl", 32'({bus.oCalcReset, oBusy, bus.oCalcEnable, bus.oCalcValid}), 32'b1110);
        check_eq("clr_m", 32'(bus.oCalcM), 32'(m));
        check_addr(m, 0);
        for (int k = 0; k < n; k++) begin
            step();
            check_eq("feed_valid", 32'({bus.oCalcValid, oBusy, bus.oCalcReset}), 32'b110);
            check_ops(m, k, n);
            if (k + 1 < n) check_addr(m, k + 1);
        end
        c_av = -1; c_err = -1; n_av = 0; n_err = 0; alpha_at_av = 32'd0;
        for (int c = 0; c <= TIMEOUT + 3; c++) begin
            step();
            iStart = (c == 1);
            iM     = 4'($urandom_range(1, 12));
            if (c == 0) check_eq("valid_drop", 32'(bus.oCalcValid), 32'd0);
            if (oAlphaValid) begin
                n_av++;
                if (c_av < 0) begin
                    c_av        = c;
                    alpha_at_av = oAlpha;
                end
            end
            if (oError) begin
                n_err++;
                if (c_err < 0) c_err = c;
            end
        end
        iStart = 1'b0;
        if (!hold && lat < TIMEOUT) begin
            check_eq("av_cycle", c_av, lat + 1);
            check_eq("av_count", n_av, 1);
            check_eq("alpha", alpha_at_av, exp_alpha);
            check_eq("err_count", n_err, 0);
            last_alpha = exp_alpha;
        end else begin
            check_eq("timeout_cycle", c_err, TIMEOUT);
            check_eq("timeout_count", n_err, 1);
            check_eq("timeout_av", n_av, 0);
        end
        check_eq("alpha_hold", oAlpha, last_alpha);
        check_eq("back_idle", 32'({oBusy, bus.oCalcEnable, bus.oCalcM}), 32'd0);
    endtask

    task automatic reset_abort(input int m, input int abort_at);
        int n_pulse;
        n_pulse  = 0;
        acc_lat  = 0;
        acc_hold = 1'b1;
        iStart   = 1'b1;
        iM       = 4'(m);
        step();
        iStart = 1'b0;
        for (int c = 1; c < abort_at; c++) step();
        check_eq("pre_abort_busy", 32'(oBusy), 32'd1);
        iReset = 1'b1;
        #1;
        check_eq("abort_calc_reset", 32'(bus.oCalcReset), 32'd1);
        step();
        iReset = 1'b0;
        check_eq("abort_idle", 32'({oBusy, bus.oCalcValid, bus.oCalcEnable}), 32'd0);
        check_eq("abort_alpha", oAlpha, 32'd0);
        for (int c = 0; c < TIMEOUT + 5; c++) begin
            step();
            if (oAlphaValid || oError || oBusy) n_pulse++;
        end
        check_eq("abort_quiet", n_pulse, 0);
        last_alpha = 32'd0;
    endtask

    initial begin
        int m, lat;
        bit hold;
        for (int i = 0; i < 16; i++) begin
            acf[i]   = FP_ZERO;
            model[i] = FP_ZERO;
        end
        iReset = 1'b1;
        step();
        step();
        check_eq("rst_calc_reset", 32'(bus.oCalcReset), 32'd1);
        check_eq("rst_ctrl", 32'({oBusy, oAlphaValid, oError, bus.oCalcValid, bus.oCalcEnable}), 32'd0);
        iReset = 1'b0;
        step();
        check_eq("rst_alpha", oAlpha, 32'd0);
        check_eq("rst_addr", 32'({bus.oACFAddr1, bus.oACFAddr2, bus.oModelAddr1, bus.oModelAddr2}), 32'd0);
        check_eq("rst_m_reset", 32'({bus.oCalcM, bus.oCalcReset}), 32'd0);
        check_eq("rst_ops", bus.oACF1 | bus.oACF2 | bus.oModel1 | bus.oModel2, 32'd0);

        model[0] = FP_ONE; model[1] = r2f(5.0); acf[0] = r2f(7.0); acf[1] = r2f(2.0);
        run_txn(1, 2, 1'b0, 32'h4000_0000);

        model[0] = FP_ONE; model[1] = r2f(0.5); acf[1] = r2f(4.0); acf[2] = r2f(2.0);
        run_txn(2, 0, 1'b0, 32'h4080_0000);

        for (int i = 0; i < 3; i++) model[i] = FP_ONE;
        model[3] = r2f(8.0); acf[0] = r2f(9.0);
        acf[1] = r2f(1.0); acf[2] = r2f(2.0); acf[3] = r2f(3.0);
        run_txn(3, 5, 1'b0, 32'h40C0_0000);

        for (int i = 0; i < 16; i++) begin
            acf[i]   = FP_ONE;
            model[i] = FP_ONE;
        end
        run_txn(12, 3, 1'b0, 32'h4140_0000);

        run_txn(0, 0, 1'b0, 32'd0);
        run_txn(13, 0, 1'b0, 32'd0);
        run_txn(5, 0, 1'b1, 32'd0);
        run_txn(4, TIMEOUT - 1, 1'b0, 32'h4080_0000);
        run_txn(4, TIMEOUT, 1'b0, 32'd0);

        reset_abort(8, 4);
        reset_abort(4, 12);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                acf[i]   = rand_val();
                model[i] = rand_val();
            end
            m    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
            lat  = int'($urandom_range(0, 10));
            hold = ($urandom_range(0, 9) == 0);
            run_txn(m, lat, hold, ref_alpha(m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
